// File: rtl/serial_word_capture_pkg.sv
// Shared definitions for the serial word capture block: FSM states and default word width.
package serial_word_capture_pkg;

    localparam int unsigned DefaultWidth = 14;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

endpackage

// File: rtl/serial_word_capture_if.sv
// Serial-in / parallel-out handshake bundle between a bit source, the capture block and its consumer.
interface serial_word_capture_if
    import serial_word_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic             frame_start;
    logic             bit_en;
    logic             bit_in;
    logic             out_ready;
    logic             clear_err;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overrun;
    logic             frame_abort;
    logic             busy;

    modport master (
        output frame_start, bit_en, bit_in, out_ready, clear_err,
        input  word_out, word_valid, overrun, frame_abort, busy
    );

    modport slave (
        input  frame_start, bit_en, bit_in, out_ready, clear_err,
        output word_out, word_valid, overrun, frame_abort, busy
    );

endinterface

// File: rtl/capture_shift_reg.sv
// Left-shifting deserialiser: load starts a new word with d in bit 0, shift_en appends d at bit 0.
module capture_shift_reg
    import serial_word_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= WIDTH'(d);
        end else if (shift_en) begin
            data_q <= {data_q[WIDTH-2:0], d};
        end
    end

    assign q = data_q;

endmodule

// File: rtl/serial_word_capture.sv
// Frames a qualified serial bit stream into WIDTH-bit words with a valid/ready output register
// and sticky overrun / frame-abort flags.
module serial_word_capture
    import serial_word_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic                  clk,
    input logic                  resetn,
    serial_word_capture_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;

    logic             sr_load, sr_shift, complete, abort_set, overrun_set;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] new_word;
    logic             unused_sr_msb;

    capture_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .resetn   (resetn),
        .load     (sr_load),
        .shift_en (sr_shift),
        .d        (bus.bit_in),
        .q        (sr_q)
    );

    // The completing bit is taken straight from bit_in so the word lands one edge after it.
    assign new_word      = {sr_q[WIDTH-2:0], bus.bit_in};
    assign unused_sr_msb = sr_q[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        complete  = 1'b0;
        abort_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.bit_en && bus.frame_start) begin
                    sr_load = 1'b1;
                    count_d = CntW'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.bit_en) begin
                    if (count_q == CntW'(WIDTH - 1)) begin
                        complete = 1'b1;
                        count_d  = '0;
                        state_d  = StIdle;
                    end else if (bus.frame_start) begin
                        sr_load   = 1'b1;
                        count_d   = CntW'(1);
                        abort_set = 1'b1;
                    end else begin
                        sr_shift = 1'b1;
                        count_d  = count_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        word_d      = word_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;
        if (complete) begin
            if (!valid_q || bus.out_ready) begin
                word_d  = new_word;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
        // Setting a flag wins over clearing it in the same cycle.
        overrun_d = overrun_set | (overrun_q & ~bus.clear_err);
        abort_d   = abort_set | (abort_q & ~bus.clear_err);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            count_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.word_out    = word_q;
    assign bus.word_valid  = valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = (state_q == StShift);

endmodule

// File: tb/tb_serial_word_capture.sv
// Directed bench for serial_word_capture: nominal, gapped, overrun, abort, simultaneous, reset.
module tb_serial_word_capture;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    serial_word_capture_if #(.WIDTH(14)) bus ();

    serial_word_capture #(
        .WIDTH (14)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic fs, input logic b);
        bus.bit_en      = 1'b1;
        bus.frame_start = fs;
        bus.bit_in      = b;
        @(posedge clk);
        #1;
        bus.bit_en      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    // Sends the top n bits of w, MSB first; frame_start only on the first bit if first_fs.
    task automatic send_bits(input logic [13:0] w, input int n, input logic first_fs);
        for (int i = 0; i < n; i++) begin
            send_bit(first_fs && (i == 0), w[13-i]);
        end
    endtask

    task automatic send_word(input logic [13:0] w);
        send_bits(w, 14, 1'b1);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [13:0] w;
        n_checks        = 0;
        n_errors        = 0;
        resetn          = 1'b0;
        bus.frame_start = 1'b0;
        bus.bit_en      = 1'b0;
        bus.bit_in      = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clear_err   = 1'b0;

        // Reset state
        idle_cycle();
        idle_cycle();
        chk("rst_word", 32'(bus.word_out), 32'h0);
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        chk("rst_abort", 32'(bus.frame_abort), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        resetn = 1'b1;
        idle_cycle();

        // Bits without frame_start are dropped in IDLE
        send_bit(1'b0, 1'b1);
        chk("idle_discard_busy", 32'(bus.busy), 32'h0);

        // Nominal frame
        bus.out_ready = 1'b1;
        w = 14'b10110011100010;
        send_bits(w, 13, 1'b1);
        chk("nom_busy_pre", 32'(bus.busy), 32'h1);
        chk("nom_valid_pre", 32'(bus.word_valid), 32'h0);
        send_bit(1'b0, w[0]);
        chk("nom_word", 32'(bus.word_out), 32'h2CE2);
        chk("nom_valid", 32'(bus.word_valid), 32'h1);
        chk("nom_busy_post", 32'(bus.busy), 32'h0);
        idle_cycle();
        chk("nom_consumed", 32'(bus.word_valid), 32'h0);

        // Gapped frame: gap cycles carry frame_start=1 and a flipped bit, both ignored
        for (int i = 0; i < 14; i++) begin
            send_bit(i == 0, w[13-i]);
            if (i == 13) begin
                chk("gap_word", 32'(bus.word_out), 32'h2CE2);
                chk("gap_valid", 32'(bus.word_valid), 32'h1);
            end
            bus.frame_start = 1'b1;
            bus.bit_in      = ~w[13-i];
            idle_cycle();
            bus.frame_start = 1'b0;
            if (i < 13) begin
                chk("gap_busy_hold", 32'(bus.busy), 32'h1);
                chk("gap_abort_none", 32'(bus.frame_abort), 32'h0);
            end
        end
        chk("gap_consumed", 32'(bus.word_valid), 32'h0);

        // Overrun: two frames with no consumer
        bus.out_ready = 1'b0;
        send_word(14'h3FFF);
        chk("ovr_first_word", 32'(bus.word_out), 32'h3FFF);
        chk("ovr_first_flag", 32'(bus.overrun), 32'h0);
        send_word(14'h0001);
        chk("ovr_word_kept", 32'(bus.word_out), 32'h3FFF);
        chk("ovr_valid", 32'(bus.word_valid), 32'h1);
        chk("ovr_flag", 32'(bus.overrun), 32'h1);
        bus.clear_err = 1'b1;
        idle_cycle();
        bus.clear_err = 1'b0;
        chk("ovr_cleared", 32'(bus.overrun), 32'h0);
        chk("ovr_valid_held", 32'(bus.word_valid), 32'h1);
        bus.out_ready = 1'b1;
        idle_cycle();
        chk("ovr_consumed", 32'(bus.word_valid), 32'h0);

        // Abort after 5 bits; restart collides with clear_err, set must win
        send_bits(14'h3300, 5, 1'b1);
        chk("abt_busy", 32'(bus.busy), 32'h1);
        chk("abt_pre", 32'(bus.frame_abort), 32'h0);
        bus.clear_err = 1'b1;
        send_bit(1'b1, 1'b1);
        bus.clear_err = 1'b0;
        chk("abt_set_wins", 32'(bus.frame_abort), 32'h1);
        w = 14'h2AAA << 1;
        send_bits(w, 13, 1'b0);
        chk("abt_word", 32'(bus.word_out), 32'h2AAA);
        chk("abt_valid", 32'(bus.word_valid), 32'h1);
        chk("abt_flag", 32'(bus.frame_abort), 32'h1);
        bus.clear_err = 1'b1;
        idle_cycle();
        bus.clear_err = 1'b0;
        chk("abt_cleared", 32'(bus.frame_abort), 32'h0);

        // frame_start on the completing bit completes normally
        w = 14'h1555;
        send_bits(w, 13, 1'b1);
        send_bit(1'b1, w[0]);
        chk("fs_last_word", 32'(bus.word_out), 32'h1555);
        chk("fs_last_abort", 32'(bus.frame_abort), 32'h0);
        chk("fs_last_busy", 32'(bus.busy), 32'h0);
        idle_cycle();

        // Completion on the same cycle the old word is consumed
        bus.out_ready = 1'b0;
        send_word(14'h1234);
        chk("sim_first", 32'(bus.word_out), 32'h1234);
        w = 14'h0F0F;
        send_bits(w, 13, 1'b1);
        chk("sim_hold", 32'(bus.word_out), 32'h1234);
        bus.out_ready = 1'b1;
        send_bit(1'b0, w[0]);
        chk("sim_word", 32'(bus.word_out), 32'h0F0F);
        chk("sim_valid", 32'(bus.word_valid), 32'h1);
        chk("sim_overrun", 32'(bus.overrun), 32'h0);
        idle_cycle();
        chk("sim_consumed", 32'(bus.word_valid), 32'h0);

        // Reset mid-frame with a pending word
        bus.out_ready = 1'b0;
        send_word(14'h0ABC);
        send_bits(14'h3F00, 7, 1'b1);
        chk("mid_busy", 32'(bus.busy), 32'h1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_word", 32'(bus.word_out), 32'h0);
        chk("mid_rst_valid", 32'(bus.word_valid), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_flags", 32'({bus.overrun, bus.frame_abort}), 32'h0);
        idle_cycle();
        resetn = 1'b1;
        send_bit(1'b0, 1'b1);
        chk("mid_post_discard", 32'(bus.busy), 32'h0);
        bus.out_ready = 1'b1;
        send_word(14'h2C5A);
        chk("mid_word", 32'(bus.word_out), 32'h2C5A);
        chk("mid_valid", 32'(bus.word_valid), 32'h1);
        chk("mid_flags", 32'({bus.overrun, bus.frame_abort}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_word_capture.md
SERIAL_WORD_CAPTURE -- requirements
Module: serial_word_capture

Interface
REQ-001 Parameter WIDTH, default 14, SHALL set the assembled word width in bits (legal range 2..32).
REQ-002 Port clk, input, 1 bit, SHALL be the single rising-edge clock for all state.
REQ-003 Port resetn, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port frame_start, input, 1 bit, SHALL mark the first bit of a frame; it is sampled only when bit_en=1.
REQ-005 Port bit_en, input, 1 bit, SHALL qualify bit_in; one serial bit is taken per clk cycle with bit_en=1.
REQ-006 Port bit_in, input, 1 bit, SHALL be the serial data bit.
REQ-007 Port out_ready, input, 1 bit, SHALL be asserted by the consumer when it can accept word_out.
REQ-008 Port clear_err, input, 1 bit, SHALL clear the sticky error flags.
REQ-009 Port word_out, output, WIDTH bits, SHALL be the assembled parallel word.
REQ-010 Port word_valid, output, 1 bit, SHALL flag that word_out holds an unconsumed word.
REQ-011 Port overrun, output, 1 bit, SHALL be a sticky flag indicating a completed word was dropped.
REQ-012 Port frame_abort, output, 1 bit, SHALL be a sticky flag indicating a partial frame was restarted.
REQ-013 Port busy, output, 1 bit, SHALL be 1 while the block is in state SHIFT.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-015 In IDLE, bit_en=1 with frame_start=1 SHALL load bit_in as the first bit, set the count to 1, and go to SHIFT; bit_en=1 with frame_start=0 SHALL discard the bit.
REQ-016 In SHIFT, each bit_en=1 SHALL shift the internal register left and insert bit_in at bit 0, so the first received bit ends in bit WIDTH-1; the count SHALL increment.
REQ-017 A bit_en=1 cycle that brings the count to WIDTH SHALL complete the word; the full word SHALL be offered at the output on the next clk edge (1-cycle latency from the last bit); the FSM SHALL return to IDLE and the count SHALL reset to 0.
REQ-018 Cycles with bit_en=0 SHALL hold the shift register, the count, and the state unchanged.
REQ-019 In SHIFT, frame_start=1 with bit_en=1 before completion SHALL discard the partial word, set frame_abort, and restart with bit_in as the new first bit (count=1).
REQ-020 On the same completing cycle, frame_start=1 SHALL complete the word normally and SHALL NOT set frame_abort.
REQ-021 Handshake: a word is consumed on any cycle with word_valid=1 and out_ready=1; word_out SHALL stay stable while word_valid=1 and the word is unconsumed.
REQ-022 Completion with word_valid=0 SHALL load word_out and set word_valid=1.
REQ-023 Completion with word_valid=1 and out_ready=1 in the same cycle SHALL load the new word and keep word_valid=1.
REQ-024 Completion with word_valid=1 and out_ready=0 SHALL drop the new word, keep the old word_out, and set overrun.
REQ-025 Consumption without completion SHALL clear word_valid on the next edge.
REQ-026 clear_err=1 SHALL clear overrun and frame_abort; if a set condition occurs in the same cycle, the set SHALL take priority.

Reset
REQ-027 While resetn=0, the FSM SHALL be in IDLE, with count=0, the shift register=0, word_out=0, word_valid=0, overrun=0, frame_abort=0, and busy=0.
REQ-028 Reset asserted mid-frame or while word_valid=1 SHALL discard all data without raising any flag.
REQ-029 After resetn deasserts, the first bit SHALL be accepted only with frame_start=1.

Structure
REQ-030 State encodings IDLE/SHIFT and the default word-width constant 14 SHALL live in the shared project package.
REQ-031 The bit-shift datapath SHALL be one sub-module, capture_shift_reg, with ports clk, resetn, load, shift_en, and d; the FSM, counter, and output register stay in the top level.

Verification
REQ-032 Nominal: frame_start+bit_en, then 14 bits 1,0,1,1,0,0,1,1,1,0,0,0,1,0 with out_ready=1 -> word_out=14'b10110011100010, word_valid=1 one cycle after the last bit.
REQ-033 Gapped: the same 14 bits with bit_en=0 on alternating cycles -> an identical word_out; count and data are held during the gaps.
REQ-034 Overrun: out_ready=0, two back-to-back frames 14'h3FFF then 14'h0001 -> word_out=14'h3FFF, overrun=1; clear_err -> overrun=0.
REQ-035 Abort: frame_start reasserted after 5 bits, then a full 14-bit 14'h2AAA frame -> frame_abort=1, word_out=14'h2AAA.
REQ-036 Simultaneous: a second frame completes on the same cycle the consumer asserts out_ready -> the new word is loaded, word_valid stays 1, overrun=0.
REQ-037 Reset mid-frame: resetn pulsed low after 7 bits -> all outputs 0; the next full frame is captured correctly.
